control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_control_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle instruction control sequencer
//
// Purpose: steps a small CPU datapath through fetch, decode and per-opcode
// execute states, driving one-hot-style datapath strobes from the current state.
// Memory states stall on mem_ready; illegal opcodes and HLT park in HALT.
//
// Optional feature: define CTRL_CALL_STACK_EN to enable CALL (7) / RET (8).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   mem_ready                memory transfer completes in a cycle where high
//   ir_opcode/ir_op1/ir_op2  instruction register fields
//   flag_carry, flag_zero    ALU flags (jump conditions)
//   state                    current state code (8 bits)
//   c_*                      datapath strobes, c_halt, c_err
//   instr_done               1-cycle pulse when an instruction retires

module control_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int OPERAND_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ready,
  input  logic [OPCODE_W-1:0]  ir_opcode,
  input  logic [OPERAND_W-1:0] ir_op1,
  input  logic [OPERAND_W-1:0] ir_op2,
  input  logic                 flag_carry,
  input  logic                 flag_zero,
  output logic [7:0]           state,
  output logic                 c_pc_inc,
  output logic                 c_pc_load,
  output logic                 c_pc_out,
  output logic                 c_ir_in,
  output logic                 c_mar_in,
  output logic                 c_mem_out,
  output logic                 c_mem_in,
  output logic                 c_rf_in,
  output logic                 c_rf_out,
  output logic                 c_alu_exec,
  output logic                 c_alu_out,
  output logic                 c_sp_out,
  output logic                 c_sp_inc,
  output logic                 c_sp_dec,
  output logic                 c_halt,
  output logic                 c_err,
  output logic                 instr_done
);

  typedef enum logic [4:0] {
    BOOT       = 5'd0,
    FETCH_PC   = 5'd1,
    FETCH_INST = 5'd2,
    DECODE     = 5'd3,
    MOV_REG    = 5'd4,
    SET_REG    = 5'd5,
    SET_MAR    = 5'd6,
    SET_MEM    = 5'd7,
    ALU_EXEC   = 5'd8,
    ALU_OUT    = 5'd9,
    JUMP       = 5'd10,
    FETCH_SP   = 5'd11,
    STORE_PC   = 5'd12,
    INC_SP     = 5'd13,
    DEC_SP     = 5'd14,
    RET        = 5'd15,
    SKIP       = 5'd16,
    HALT       = 5'd17,
    FETCH_ARG  = 5'd18
  } state_t;

  state_t cur, nxt;
  logic   err_q, err_set;
  logic   jump_cond, jump_taken, is_call;

  // ir_op1 selects registers in the datapath; the sequencer never looks at it.
  logic unused_op1;
  assign unused_op1 = ^ir_op1;

  // Opcodes with any bit above the low nibble set are illegal.
  logic [OPCODE_W-1:0] op_upper;
  logic [3:0]          op;
  logic                op_ok;
  assign op_upper = ir_opcode >> 4;
  assign op       = ir_opcode[3:0];
  assign op_ok    = (op_upper == '0);

  always_comb begin
    jump_cond = 1'b0;
    if      (ir_op2 == OPERAND_W'(0)) jump_cond = 1'b1;
    else if (ir_op2 == OPERAND_W'(1)) jump_cond = flag_zero;
    else if (ir_op2 == OPERAND_W'(2)) jump_cond = ~flag_zero;
    else if (ir_op2 == OPERAND_W'(3)) jump_cond = flag_carry;
    else if (ir_op2 == OPERAND_W'(4)) jump_cond = ~flag_carry;
  end

`ifdef CTRL_CALL_STACK_EN
  assign is_call = op_ok && (op == 4'd7);
`else
  assign is_call = 1'b0;
`endif
  // CALL reuses the JUMP state but always loads the PC.
  assign jump_taken = is_call | jump_cond;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= BOOT;
      err_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  // Next state and retire pulse. Steps shared by several opcodes
  // (FETCH_ARG, SET_MAR, FETCH_SP) branch on the held IR opcode.
  always_comb begin
    nxt        = cur;
    err_set    = 1'b0;
    instr_done = 1'b0;
    case (cur)
      BOOT:       nxt = FETCH_PC;
      FETCH_PC:   nxt = FETCH_INST;
      FETCH_INST: if (mem_ready) nxt = DECODE;
      DECODE: begin
        nxt = HALT;
        if (op_ok) begin
          case (op)
            4'd0: begin nxt = FETCH_PC; instr_done = 1'b1; end
            4'd1: nxt = MOV_REG;
            4'd2: nxt = FETCH_ARG;
            4'd3: nxt = SET_MAR;
            4'd4: nxt = SET_MAR;
            4'd5: nxt = ALU_EXEC;
            4'd6: nxt = FETCH_ARG;
`ifdef CTRL_CALL_STACK_EN
            4'd7: nxt = FETCH_SP;
            4'd8: nxt = DEC_SP;
`endif
            4'd15: nxt = HALT;
            default: err_set = 1'b1;
          endcase
        end else begin
          err_set = 1'b1;
        end
      end
      MOV_REG:   begin nxt = FETCH_PC; instr_done = 1'b1; end
      FETCH_ARG: nxt = (op == 4'd2) ? SET_REG : JUMP;
      SET_MAR:   nxt = (op == 4'd3) ? SET_REG : SET_MEM;
      SET_REG, SET_MEM, JUMP:
        if (mem_ready) begin nxt = FETCH_PC; instr_done = 1'b1; end
      ALU_EXEC:  nxt = ALU_OUT;
      ALU_OUT:   begin nxt = FETCH_PC; instr_done = 1'b1; end
`ifdef CTRL_CALL_STACK_EN
      FETCH_SP:  nxt = (op == 4'd7) ? STORE_PC : RET;
      STORE_PC:  if (mem_ready) nxt = INC_SP;
      INC_SP:    nxt = FETCH_ARG;
      DEC_SP:    nxt = FETCH_SP;
      RET:       if (mem_ready) nxt = SKIP;
      SKIP:      begin nxt = FETCH_PC; instr_done = 1'b1; end
`endif
      HALT:      nxt = HALT;
      default:   nxt = HALT;
    endcase
  end

  // Strobes depend on the state alone (JUMP also on its condition), so they
  // stay asserted across mem_ready stalls.
  always_comb begin
    c_pc_inc   = 1'b0;
    c_pc_load  = 1'b0;
    c_pc_out   = 1'b0;
    c_ir_in    = 1'b0;
    c_mar_in   = 1'b0;
    c_mem_out  = 1'b0;
    c_mem_in   = 1'b0;
    c_rf_in    = 1'b0;
    c_rf_out   = 1'b0;
    c_alu_exec = 1'b0;
    c_alu_out  = 1'b0;
    c_sp_out   = 1'b0;
    c_sp_inc   = 1'b0;
    c_sp_dec   = 1'b0;
    case (cur)
      FETCH_PC, FETCH_ARG: begin c_pc_out = 1'b1; c_mar_in = 1'b1; c_pc_inc = 1'b1; end
      FETCH_INST: begin c_mem_out = 1'b1; c_ir_in  = 1'b1; end
      MOV_REG:    begin c_rf_out  = 1'b1; c_rf_in  = 1'b1; end
      SET_REG:    begin c_mem_out = 1'b1; c_rf_in  = 1'b1; end
      SET_MAR:    begin c_rf_out  = 1'b1; c_mar_in = 1'b1; end
      SET_MEM:    begin c_rf_out  = 1'b1; c_mem_in = 1'b1; end
      ALU_EXEC:   c_alu_exec = 1'b1;
      ALU_OUT:    begin c_alu_out = 1'b1; c_rf_in = 1'b1; end
      JUMP:       begin c_mem_out = 1'b1; c_pc_load = jump_taken; end
`ifdef CTRL_CALL_STACK_EN
      FETCH_SP:   begin c_sp_out  = 1'b1; c_mar_in  = 1'b1; end
      STORE_PC:   begin c_pc_out  = 1'b1; c_mem_in  = 1'b1; end
      INC_SP:     c_sp_inc = 1'b1;
      DEC_SP:     c_sp_dec = 1'b1;
      RET:        begin c_mem_out = 1'b1; c_pc_load = 1'b1; end
      SKIP:       c_pc_inc = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state  = {3'b000, cur};
  assign c_halt = (cur == HALT);
  assign c_err  = err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer

module tb_control_sequencer;

  localparam int OPCODE_W  = 5;
  localparam int OPERAND_W = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 mem_ready;
  logic [OPCODE_W-1:0]  ir_opcode;
  logic [OPERAND_W-1:0] ir_op1, ir_op2;
  logic                 flag_carry, flag_zero;
  logic [7:0]           state;
  logic c_pc_inc, c_pc_load, c_pc_out, c_ir_in, c_mar_in, c_mem_out, c_mem_in;
  logic c_rf_in, c_rf_out, c_alu_exec, c_alu_out, c_sp_out, c_sp_inc, c_sp_dec;
  logic c_halt, c_err, instr_done;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.OPCODE_W(OPCODE_W), .OPERAND_W(OPERAND_W)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready),
    .ir_opcode(ir_opcode), .ir_op1(ir_op1), .ir_op2(ir_op2),
    .flag_carry(flag_carry), .flag_zero(flag_zero),
    .state(state),
    .c_pc_inc(c_pc_inc), .c_pc_load(c_pc_load), .c_pc_out(c_pc_out),
    .c_ir_in(c_ir_in), .c_mar_in(c_mar_in), .c_mem_out(c_mem_out),
    .c_mem_in(c_mem_in), .c_rf_in(c_rf_in), .c_rf_out(c_rf_out),
    .c_alu_exec(c_alu_exec), .c_alu_out(c_alu_out), .c_sp_out(c_sp_out),
    .c_sp_inc(c_sp_inc), .c_sp_dec(c_sp_dec),
    .c_halt(c_halt), .c_err(c_err), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Strobe vector, bit 13 down to bit 0.
  logic [13:0] strb;
  assign strb = {c_pc_inc, c_pc_load, c_pc_out, c_ir_in, c_mar_in, c_mem_out, c_mem_in,
                 c_rf_in, c_rf_out, c_alu_exec, c_alu_out, c_sp_out, c_sp_inc, c_sp_dec};

  localparam logic [13:0] PC_INC   = 14'h2000;
  localparam logic [13:0] PC_LOAD  = 14'h1000;
  localparam logic [13:0] PC_OUT   = 14'h0800;
  localparam logic [13:0] IR_IN    = 14'h0400;
  localparam logic [13:0] MAR_IN   = 14'h0200;
  localparam logic [13:0] MEM_OUT  = 14'h0100;
  localparam logic [13:0] MEM_IN   = 14'h0080;
  localparam logic [13:0] RF_IN    = 14'h0040;
  localparam logic [13:0] RF_OUT   = 14'h0020;
  localparam logic [13:0] ALU_EXEC = 14'h0010;
  localparam logic [13:0] ALU_OUT  = 14'h0008;
  localparam logic [13:0] SP_OUT   = 14'h0004;
  localparam logic [13:0] SP_INC   = 14'h0002;
  localparam logic [13:0] SP_DEC   = 14'h0001;
  localparam logic [13:0] FPC      = PC_OUT | MAR_IN | PC_INC;
  localparam logic [13:0] FIN      = MEM_OUT | IR_IN;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already set; checks the
  // current cycle and moves on to the next falling edge.
  task automatic step(input string tag, input int st, input logic [13:0] sb, input logic dn);
    #1;
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".strb"},  32'(strb),  32'(sb));
    check({tag, ".done"},  32'(instr_done), 32'(dn));
    @(negedge clk);
  endtask

  task automatic fetch(input string tag, input logic [OPCODE_W-1:0] opc);
    ir_opcode = opc;
    step({tag, ".fpc"}, 1, FPC, 1'b0);
    step({tag, ".fin"}, 2, FIN, 1'b0);
  endtask

  task automatic reset_release(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".rst_state"}, 32'(state), 32'd0);
    check({tag, ".rst_strb"},  32'(strb),  32'd0);
    check({tag, ".rst_err"},   32'(c_err), 32'd0);
    check({tag, ".rst_halt"},  32'(c_halt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    step({tag, ".boot"}, 0, 14'h0, 1'b0);
  endtask

  task automatic expect_halt(input string tag, input int cycles, input logic err);
    for (int i = 0; i < cycles; i++) begin
      #1;
      check({tag, ".hstate"}, 32'(state), 32'd17);
      check({tag, ".hhalt"},  32'(c_halt), 32'd1);
      check({tag, ".herr"},   32'(c_err), 32'(err));
      check({tag, ".hstrb"},  32'(strb | 14'(instr_done)), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; mem_ready = 1'b1; ir_opcode = '0; ir_op1 = '0; ir_op2 = '0;
    flag_carry = 1'b0; flag_zero = 1'b0;
    @(negedge clk);
    step("reset", 0, 14'h0, 1'b0);
    check("reset.halt", 32'(c_halt), 32'd0);
    check("reset.err",  32'(c_err),  32'd0);

    // Release and NOP: 0,1,2,3,1.
    rst = 1'b0;
    step("nop.boot", 0, 14'h0, 1'b0);
    fetch("nop", 5'd0);
    step("nop.dec", 3, 14'h0, 1'b1);

    // LDI with three stalled cycles in SET_REG.
    fetch("ldi", 5'd2);
    step("ldi.dec", 3, 14'h0, 1'b0);
    mem_ready = 1'b0;
    step("ldi.arg", 18, FPC, 1'b0);
    step("ldi.sr1", 5, MEM_OUT | RF_IN, 1'b0);
    step("ldi.sr2", 5, MEM_OUT | RF_IN, 1'b0);
    step("ldi.sr3", 5, MEM_OUT | RF_IN, 1'b0);
    mem_ready = 1'b1;
    step("ldi.sr4", 5, MEM_OUT | RF_IN, 1'b1);

    // JMP on zero: not taken, then taken; carry-clear taken; code 6 never.
    ir_op2 = 3'd1; flag_zero = 1'b0;
    fetch("jz0", 5'd6);
    step("jz0.dec", 3, 14'h0, 1'b0);
    step("jz0.arg", 18, FPC, 1'b0);
    step("jz0.jmp", 10, MEM_OUT, 1'b1);
    flag_zero = 1'b1;
    fetch("jz1", 5'd6);
    step("jz1.dec", 3, 14'h0, 1'b0);
    step("jz1.arg", 18, FPC, 1'b0);
    step("jz1.jmp", 10, MEM_OUT | PC_LOAD, 1'b1);
    ir_op2 = 3'd4; flag_carry = 1'b0;
    fetch("jnc", 5'd6);
    step("jnc.dec", 3, 14'h0, 1'b0);
    step("jnc.arg", 18, FPC, 1'b0);
    step("jnc.jmp", 10, MEM_OUT | PC_LOAD, 1'b1);
    ir_op2 = 3'd6;
    fetch("jnv", 5'd6);
    step("jnv.dec", 3, 14'h0, 1'b0);
    step("jnv.arg", 18, FPC, 1'b0);
    step("jnv.jmp", 10, MEM_OUT, 1'b1);

    // MOV, LD, ST, ALU.
    fetch("mov", 5'd1);
    step("mov.dec", 3, 14'h0, 1'b0);
    step("mov.mov", 4, RF_OUT | RF_IN, 1'b1);
    fetch("ld", 5'd3);
    step("ld.dec", 3, 14'h0, 1'b0);
    step("ld.mar", 6, RF_OUT | MAR_IN, 1'b0);
    step("ld.reg", 5, MEM_OUT | RF_IN, 1'b1);
    fetch("st", 5'd4);
    step("st.dec", 3, 14'h0, 1'b0);
    step("st.mar", 6, RF_OUT | MAR_IN, 1'b0);
    step("st.mem", 7, RF_OUT | MEM_IN, 1'b1);
    fetch("alu", 5'd5);
    step("alu.dec", 3, 14'h0, 1'b0);
    step("alu.ex", 8, ALU_EXEC, 1'b0);
    step("alu.out", 9, ALU_OUT | RF_IN, 1'b1);

    // Reset during a FETCH_INST stall takes effect without a clock edge.
    ir_opcode = 5'd0;
    step("stall.fpc", 1, FPC, 1'b0);
    mem_ready = 1'b0;
    step("stall.fi1", 2, FIN, 1'b0);
    step("stall.fi2", 2, FIN, 1'b0);
    reset_release("stall");

`ifdef CTRL_CALL_STACK_EN
    fetch("call", 5'd7);
    step("call.dec", 3, 14'h0, 1'b0);
    step("call.fsp", 11, SP_OUT | MAR_IN, 1'b0);
    step("call.spc", 12, PC_OUT | MEM_IN, 1'b0);
    step("call.inc", 13, SP_INC, 1'b0);
    step("call.arg", 18, FPC, 1'b0);
    ir_op2 = 3'd7;
    step("call.jmp", 10, MEM_OUT | PC_LOAD, 1'b1);
    fetch("ret", 5'd8);
    step("ret.dec", 3, 14'h0, 1'b0);
    step("ret.dsp", 14, SP_DEC, 1'b0);
    step("ret.fsp", 11, SP_OUT | MAR_IN, 1'b0);
    step("ret.ret", 15, MEM_OUT | PC_LOAD, 1'b0);
    step("ret.skp", 16, PC_INC, 1'b1);
    step("ret.next", 1, FPC, 1'b0);
    reset_release("cs");
`else
    fetch("call", 5'd7);
    step("call.dec", 3, 14'h0, 1'b0);
    expect_halt("call", 3, 1'b1);
    reset_release("call");
    fetch("ret", 5'd8);
    step("ret.dec", 3, 14'h0, 1'b0);
    expect_halt("ret", 2, 1'b1);
    reset_release("ret");
`endif

    // HLT: halted without error.
    fetch("hlt", 5'd15);
    step("hlt.dec", 3, 14'h0, 1'b0);
    expect_halt("hlt", 4, 1'b0);
    reset_release("hlt");

    // Opcode 9: illegal, held 20 cycles, reset clears the error.
    fetch("op9", 5'd9);
    step("op9.dec", 3, 14'h0, 1'b0);
    expect_halt("op9", 20, 1'b1);
    reset_release("op9");

    // Upper opcode bit set over an otherwise legal LDI is illegal.
    fetch("hi", 5'h12);
    step("hi.dec", 3, 14'h0, 1'b0);
    expect_halt("hi", 3, 1'b1);
    reset_release("hi");
    step("hi.after", 1, FPC, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL timeout: simulation exceeded time budget");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
